// File: rtl/two_bit_comparator_if.sv
// Operand/result bundle between a mesh node and its 2-bit label comparator.
// The node side drives the operands and enable; the comparator side returns the flags.
interface two_bit_comparator_if;
  logic [1:0] a;
  logic [1:0] b;
  logic       en;
  logic       y;
  logic       eq_q;
  logic       gt_q;
  logic       lt_q;
  logic [2:0] match_cnt;

  modport master (
    output a, b, en,
    input  y, eq_q, gt_q, lt_q, match_cnt
  );

  modport slave (
    input  a, b, en,
    output y, eq_q, gt_q, lt_q, match_cnt
  );
endinterface

// File: rtl/two_bit_comparator.sv
// Unsigned 2-bit label comparator: combinational equality for the neighbour-match path,
// plus registered eq/gt/lt flags and a saturating match counter for status.
module two_bit_comparator (
  input logic                 clk,
  input logic                 rst,
  two_bit_comparator_if.slave bus
);

  logic       eq;
  logic       gt;
  logic       lt;
  logic       eq_q, eq_d;
  logic       gt_q, gt_d;
  logic       lt_q, lt_d;
  logic [2:0] match_cnt_q, match_cnt_d;

  // Magnitude decided MSB first; lt is the mirror image of gt.
  always_comb begin
    eq = (bus.a[1] ~^ bus.b[1]) & (bus.a[0] ~^ bus.b[0]);
    gt = (bus.a[1] & ~bus.b[1]) | ((bus.a[1] ~^ bus.b[1]) & bus.a[0] & ~bus.b[0]);
    lt = (~bus.a[1] & bus.b[1]) | ((bus.a[1] ~^ bus.b[1]) & ~bus.a[0] & bus.b[0]);
  end

  always_comb begin
    eq_d        = eq_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    match_cnt_d = match_cnt_q;
    if (!rst) begin
      eq_d        = 1'b0;
      gt_d        = 1'b0;
      lt_d        = 1'b0;
      match_cnt_d = 3'd0;
    end else if (bus.en) begin
      eq_d = eq;
      gt_d = gt;
      lt_d = lt;
      if (eq && (match_cnt_q != 3'd7)) begin
        match_cnt_d = match_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    eq_q        <= eq_d;
    gt_q        <= gt_d;
    lt_q        <= lt_d;
    match_cnt_q <= match_cnt_d;
  end

  assign bus.y         = eq;
  assign bus.eq_q      = eq_q;
  assign bus.gt_q      = gt_q;
  assign bus.lt_q      = lt_q;
  assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_two_bit_comparator.sv
// Directed bench for two_bit_comparator: exhaustive operand sweep, reset, saturation,
// enable gating, mid-count reset and a node-style neighbour scan.
module tb_two_bit_comparator;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  bit   onehot_on;

  two_bit_comparator_if bus ();

  two_bit_comparator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Registered flags: one-hot once sampled, all-zero only as the reset state.
  always @(negedge clk) begin
    if (onehot_on) check("flags_onehot0", int'($onehot0({bus.eq_q, bus.gt_q, bus.lt_q})), 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    int exp_cnt;
    logic [1:0] scan_b [4];
    int scan_y  [4];
    int scan_gt [4];
    scan_b  = '{2'd1, 2'd3, 2'd2, 2'd0};
    scan_y  = '{0, 0, 1, 0};
    scan_gt = '{1, 0, 0, 1};
    pass_cnt  = 0;
    total_cnt = 0;
    onehot_on = 1'b0;
    rst    = 1'b0;
    bus.en = 1'b0;
    bus.a  = 2'd0;
    bus.b  = 2'd0;

    // Reset held with operands equal and enable high.
    bus.a  = 2'd3;
    bus.b  = 2'd3;
    bus.en = 1'b1;
    #1;
    check("rst_y_comb", int'(bus.y), 1);
    step();
    step();
    onehot_on = 1'b1;
    check("rst_eq_q", int'(bus.eq_q), 0);
    check("rst_gt_q", int'(bus.gt_q), 0);
    check("rst_lt_q", int'(bus.lt_q), 0);
    check("rst_cnt", int'(bus.match_cnt), 0);
    check("rst_y_hold", int'(bus.y), 1);
    rst = 1'b1;
    step();
    check("rel_eq_q", int'(bus.eq_q), 1);
    check("rel_cnt", int'(bus.match_cnt), 1);

    // Exhaustive sweep of all 16 pairs.
    do_reset();
    exp_cnt = 0;
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        bus.a = 2'(ia);
        bus.b = 2'(ib);
        #1;
        check($sformatf("y_a%0d_b%0d", ia, ib), int'(bus.y), (ia == ib) ? 1 : 0);
        step();
        if (ia == ib && exp_cnt < 7) exp_cnt++;
        check($sformatf("eq_a%0d_b%0d", ia, ib), int'(bus.eq_q), (ia == ib) ? 1 : 0);
        check($sformatf("gt_a%0d_b%0d", ia, ib), int'(bus.gt_q), (ia > ib) ? 1 : 0);
        check($sformatf("lt_a%0d_b%0d", ia, ib), int'(bus.lt_q), (ia < ib) ? 1 : 0);
        check($sformatf("cnt_a%0d_b%0d", ia, ib), int'(bus.match_cnt), exp_cnt);
      end
    end

    // Saturation at 7.
    do_reset();
    bus.a  = 2'd2;
    bus.b  = 2'd2;
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("sat_cnt_%0d", i), int'(bus.match_cnt), (i + 1 < 7) ? i + 1 : 7);
      check($sformatf("sat_eq_%0d", i), int'(bus.eq_q), 1);
    end

    // Enable gating.
    do_reset();
    bus.a = 2'd0;
    bus.b = 2'd1;
    step();
    check("gate_load_lt", int'(bus.lt_q), 1);
    check("gate_load_cnt", int'(bus.match_cnt), 0);
    bus.en = 1'b0;
    bus.a  = 2'd3;
    bus.b  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("gate_y_%0d", i), int'(bus.y), 0);
      step();
      check($sformatf("gate_lt_%0d", i), int'(bus.lt_q), 1);
      check($sformatf("gate_gt_%0d", i), int'(bus.gt_q), 0);
      check($sformatf("gate_cnt_%0d", i), int'(bus.match_cnt), 0);
    end

    // Mid-count reset.
    do_reset();
    bus.en = 1'b1;
    bus.a  = 2'd1;
    bus.b  = 2'd1;
    for (int i = 0; i < 5; i++) step();
    check("mid_cnt5", int'(bus.match_cnt), 5);
    rst = 1'b0;
    step();
    check("mid_rst_cnt", int'(bus.match_cnt), 0);
    check("mid_rst_eq", int'(bus.eq_q), 0);
    check("mid_rst_gt", int'(bus.gt_q), 0);
    check("mid_rst_lt", int'(bus.lt_q), 0);
    rst = 1'b1;
    step();
    check("mid_resume_cnt", int'(bus.match_cnt), 1);
    check("mid_resume_eq", int'(bus.eq_q), 1);

    // Node-style neighbour scan.
    do_reset();
    bus.a = 2'd2;
    for (int i = 0; i < 4; i++) begin
      bus.b = scan_b[i];
      #1;
      check($sformatf("scan_y_%0d", i), int'(bus.y), scan_y[i]);
      step();
      check($sformatf("scan_gt_%0d", i), int'(bus.gt_q), scan_gt[i]);
    end
    check("scan_cnt", int'(bus.match_cnt), 1);

    onehot_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
